// File: rtl/lcd_pkg.sv
// Shared LCD definitions: writer state encoding, FIFO word layout and the
// command/data flag values used by every block that produces LCD words.
package lcd_pkg;

  localparam int LCD_WORD_W = 17;
  localparam int LCD_RS_BIT = 16;
  localparam int LCD_BUS_W  = 16;
  localparam int LCD_CNT_W  = 23;

  localparam logic LCD_FLAG_CMD  = 1'b0;
  localparam logic LCD_FLAG_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_RST_LO,
    ST_RST_WAIT,
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WR_LO,
    ST_WR_HI
  } lcd_state_e;

  // States in which the panel bus is released and no word is in flight.
  function automatic logic lcd_is_quiet(input lcd_state_e s);
    return s inside {ST_IDLE, ST_RST_LO, ST_RST_WAIT};
  endfunction

endpackage

// File: rtl/lcd_bus_writer_if.sv
// FIFO read port plus panel pins of the LCD bus writer, bundled so the
// writer and its environment connect through a single port.
interface lcd_bus_writer_if;
  import lcd_pkg::*;

  logic                  rempty;
  logic [LCD_WORD_W-1:0] rdata;
  logic                  rinc;
  logic                  lcd_ready;
  logic                  lcd_busy;
  logic                  lcd_rst_n;
  logic                  lcd_cs_n;
  logic                  lcd_rs;
  logic                  lcd_wr_n;
  logic                  lcd_rd_n;
  logic [LCD_BUS_W-1:0]  lcd_data;

  modport master (
    input  rempty, rdata,
    output rinc, lcd_ready, lcd_busy, lcd_rst_n, lcd_cs_n,
           lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data
  );

  modport slave (
    output rempty, rdata,
    input  rinc, lcd_ready, lcd_busy, lcd_rst_n, lcd_cs_n,
           lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data
  );

endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed state of the LCD writer;
// it stops at zero and flags it.
module lcd_delay_cnt #(
    parameter int           W       = 23,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// Pops words from the LCD FIFO and drives them onto the 8080-style panel
// write bus; also sequences the panel hardware reset and power-up wait.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int RST_LOW_CYC  = 500,
    parameter int RST_WAIT_CYC = 6_000_000,
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_writer_if.master  bus
);

    localparam logic [LCD_CNT_W-1:0] RST_LO_LD   = LCD_CNT_W'(RST_LOW_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] RST_WAIT_LD = LCD_CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] WR_LO_LD    = LCD_CNT_W'(WR_LOW_CYC - 1);
    localparam logic [LCD_CNT_W-1:0] WR_HI_LD    = LCD_CNT_W'(WR_HIGH_CYC - 1);

    if (RST_LOW_CYC < 1 || RST_LOW_CYC > 2**LCD_CNT_W ||
        RST_WAIT_CYC < 1 || RST_WAIT_CYC > 2**LCD_CNT_W ||
        WR_LOW_CYC < 1 || WR_LOW_CYC > 2**LCD_CNT_W ||
        WR_HIGH_CYC < 1 || WR_HIGH_CYC > 2**LCD_CNT_W) begin : g_param_check
        $error("lcd_bus_writer: timing parameter outside 1..2**23");
    end

    lcd_state_e             state_q, state_d;
    logic                   cnt_load;
    logic [LCD_CNT_W-1:0]   cnt_val;
    logic                   cnt_zero;

    logic                   lcd_rst_n_q, lcd_rst_n_d;
    logic                   cs_n_q, cs_n_d;
    logic                   wr_n_q, wr_n_d;
    logic                   rs_q, rs_d;
    logic [LCD_BUS_W-1:0]   data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;

    lcd_delay_cnt #(
        .W       (LCD_CNT_W),
        .RST_VAL (RST_LO_LD)
    ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RST_LO:   if (cnt_zero) state_d = ST_RST_WAIT;
            ST_RST_WAIT: if (cnt_zero) state_d = ST_IDLE;
            ST_IDLE:     if (!bus.rempty) state_d = ST_FETCH;
            ST_FETCH:    state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_WR_LO;
            ST_WR_LO:    if (cnt_zero) state_d = ST_WR_HI;
            ST_WR_HI:    if (cnt_zero) state_d = bus.rempty ? ST_IDLE : ST_FETCH;
            default:     state_d = ST_RST_LO;
        endcase
    end

    // The counter is reloaded with N-1 on every state change; only timed states look at it.
    always_comb begin
        cnt_load = (state_d != state_q);
        cnt_val  = '0;
        unique case (state_d)
            ST_RST_LO:   cnt_val = RST_LO_LD;
            ST_RST_WAIT: cnt_val = RST_WAIT_LD;
            ST_WR_LO:    cnt_val = WR_LO_LD;
            ST_WR_HI:    cnt_val = WR_HI_LD;
            default:     cnt_val = '0;
        endcase
    end

    // Pins are decoded from the next state so the registered outputs track the state register.
    always_comb begin
        lcd_rst_n_d = (state_d != ST_RST_LO);
        wr_n_d      = (state_d != ST_WR_LO);
        busy_d      = !lcd_is_quiet(state_d);
        ready_d     = ready_q || (state_d == ST_IDLE);
        cs_n_d      = cs_n_q;
        rs_d        = rs_q;
        data_d      = data_q;
        if (state_d == ST_LOAD) begin
            cs_n_d = 1'b0;
        end else if (lcd_is_quiet(state_d)) begin
            cs_n_d = 1'b1;
        end
        if (state_q == ST_LOAD) begin
            data_d = bus.rdata[LCD_BUS_W-1:0];
            rs_d   = bus.rdata[LCD_RS_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RST_LO;
            lcd_rst_n_q <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rs_q        <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rinc      = (state_q == ST_FETCH);
    assign bus.lcd_rst_n = lcd_rst_n_q;
    assign bus.lcd_cs_n  = cs_n_q;
    assign bus.lcd_wr_n  = wr_n_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_data  = data_q;
    assign bus.lcd_ready = ready_q;
    assign bus.lcd_busy  = busy_q;
    assign bus.lcd_rd_n  = 1'b1;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: a FIFO model feeds words, a monitor decodes panel
// write strobes and checks them against a push-order scoreboard.
module tb_lcd_bus_writer;
    import lcd_pkg::*;

    localparam int RST_LOW  = 4;
    localparam int RST_WAIT = 8;
    localparam int WR_LOW   = 2;
    localparam int WR_HIGH  = 2;
    localparam int PERIOD   = 10;
    localparam int WORD_CYC = 2 + WR_LOW + WR_HIGH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lcd_bus_writer_if bus ();

    lcd_bus_writer #(
        .RST_LOW_CYC  (RST_LOW),
        .RST_WAIT_CYC (RST_WAIT),
        .WR_LOW_CYC   (WR_LOW),
        .WR_HIGH_CYC  (WR_HIGH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #(PERIOD/2) clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a FIFO of pushed words and the strobes they must produce, in order.
    logic [16:0] fifo_q[$];
    logic [16:0] exp_q[$];
    time         fall_t[$];
    time         rise_t[$];
    time         t_rempty_fall = 0;
    time         t_last_pop = 0;
    int          done_cnt = 0;

    task automatic push(input logic [16:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // FIFO read-port model: pops on rinc, word valid from the following cycle.
    initial begin
        bus.rempty = 1'b1;
        bus.rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.rinc === 1'b1) begin
                check("rinc_after_ready", 32'(bus.lcd_ready), 32'd1);
                check("rinc_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    bus.rdata  = fifo_q.pop_front();
                    t_last_pop = $time;
                end
            end
            if (bus.rempty && fifo_q.size() != 0) t_rempty_fall = $time;
            bus.rempty = (fifo_q.size() == 0);
        end
    end

    // Strobe monitor
    logic        mon_prev_wr = 1'b1;
    logic [15:0] mon_data = '0;
    logic        mon_rs = 1'b0;
    int          mon_low = 0;
    logic        mon_stable = 1'b1;
    logic [16:0] mon_w = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev_wr && !bus.lcd_wr_n) begin
                mon_data   = bus.lcd_data;
                mon_rs     = bus.lcd_rs;
                mon_low    = 1;
                mon_stable = 1'b1;
                fall_t.push_back($time);
                check("cs_low_at_fall", 32'(bus.lcd_cs_n), 32'd0);
            end else if (!mon_prev_wr && !bus.lcd_wr_n) begin
                mon_low++;
                if (bus.lcd_data !== mon_data || bus.lcd_rs !== mon_rs) mon_stable = 1'b0;
            end else if (!mon_prev_wr && bus.lcd_wr_n && bus.lcd_rst_n) begin
                if (bus.lcd_data !== mon_data || bus.lcd_rs !== mon_rs) mon_stable = 1'b0;
                rise_t.push_back($time);
                check("data_stable", 32'(mon_stable), 32'd1);
                check("wr_low_cycles", 32'(mon_low), 32'(WR_LOW));
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_w = exp_q.pop_front();
                    check("strobe_rs", 32'(mon_rs), 32'(mon_w[16]));
                    check("strobe_data", 32'(mon_data), 32'(mon_w[15:0]));
                end
                done_cnt++;
            end
            mon_prev_wr = bus.lcd_wr_n;
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check("done_in_time", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.lcd_busy && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check("idle_in_time", 32'(bus.lcd_busy), 32'd0);
    endtask

    task automatic wait_wr_low(input int budget);
        int n = 0;
        while (bus.lcd_wr_n && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check("wr_fall_in_time", 32'(bus.lcd_wr_n), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int cs_hi;
        int base;
        logic [16:0] w;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_lcd_rst_n", 32'(bus.lcd_rst_n), 32'd0);
        check("rst_cs_n", 32'(bus.lcd_cs_n), 32'd1);
        check("rst_wr_n", 32'(bus.lcd_wr_n), 32'd1);
        check("rst_rd_n", 32'(bus.lcd_rd_n), 32'd1);
        check("rst_rs", 32'(bus.lcd_rs), 32'd0);
        check("rst_data", 32'(bus.lcd_data), 32'd0);
        check("rst_rinc", 32'(bus.rinc), 32'd0);
        check("rst_ready", 32'(bus.lcd_ready), 32'd0);
        check("rst_busy", 32'(bus.lcd_busy), 32'd0);

        // Single command already waiting in the FIFO while the panel reset runs
        push({LCD_FLAG_CMD, 16'h0029});
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!bus.lcd_rst_n && cnt < 100) begin cnt++; @(negedge clk); end
        check("panel_rst_low_cycles", 32'(cnt), 32'(RST_LOW));
        cnt = 0;
        while (!bus.lcd_ready && cnt < 100) begin
            if (!bus.lcd_rst_n) check("panel_rst_stays_high", 32'(bus.lcd_rst_n), 32'd1);
            cnt++; @(negedge clk);
        end
        check("ready_after_wait", 32'(cnt), 32'(RST_WAIT));
        #1;
        wait_done(1, 50);
        wait_idle(50);
        check("cs_high_after_cmd", 32'(bus.lcd_cs_n), 32'd1);
        check("rd_n_constant", 32'(bus.lcd_rd_n), 32'd1);

        // Latency from rempty falling in IDLE to the strobe falling
        push({LCD_FLAG_CMD, 16'h002C});
        wait_done(2, 50);
        check("idle_latency", 32'((fall_t[fall_t.size()-1] - t_rempty_fall) / PERIOD), 32'd3);
        wait_idle(50);

        // Burst: back-to-back data words keep chip select low
        fall_t.delete();
        base = done_cnt;
        repeat (3) push({LCD_FLAG_DATA, 16'hF800});
        wait_wr_low(50);
        cs_hi = 0;
        cnt = 0;
        while (done_cnt < base + 3 && cnt < 100) begin
            if (bus.lcd_cs_n) cs_hi++;
            @(negedge clk); #1; cnt++;
        end
        check("burst_done", 32'(done_cnt), 32'(base + 3));
        check("burst_cs_low", 32'(cs_hi), 32'd0);
        check("burst_strobes", 32'(fall_t.size()), 32'd3);
        if (fall_t.size() >= 3) begin
            for (int i = 1; i < 3; i++)
                check("burst_spacing", 32'((fall_t[i] - fall_t[i-1]) / PERIOD), 32'(WORD_CYC));
        end
        wait_idle(50);

        // Late arrival: second word appears while the first is mid-strobe
        fall_t.delete();
        rise_t.delete();
        base = done_cnt;
        push({LCD_FLAG_DATA, 16'h1234});
        wait_wr_low(50);
        push({LCD_FLAG_CMD, 16'h00AB});
        wait_done(base + 2, 100);
        if (rise_t.size() >= 1)
            check("late_pop_after_wr_hi", 32'((t_last_pop - rise_t[0]) / PERIOD), 32'(WR_HIGH));
        if (fall_t.size() >= 2)
            check("late_spacing", 32'((fall_t[1] - fall_t[0]) / PERIOD), 32'(WORD_CYC));
        wait_idle(50);

        // Reset in the middle of a strobe
        push({LCD_FLAG_DATA, 16'h5555});
        wait_wr_low(50);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("midrst_wr_n", 32'(bus.lcd_wr_n), 32'd1);
        check("midrst_cs_n", 32'(bus.lcd_cs_n), 32'd1);
        check("midrst_lcd_rst_n", 32'(bus.lcd_rst_n), 32'd0);
        check("midrst_ready", 32'(bus.lcd_ready), 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!bus.lcd_ready && cnt < 100) begin @(negedge clk); cnt++; end
        #1;
        check("ready_after_rerun", 32'(bus.lcd_ready), 32'd1);

        // Random words with random gaps, sometimes back-to-back
        base = done_cnt;
        for (int i = 0; i < 100; i++) begin
            w = 17'($urandom);
            push(w);
            repeat ($urandom_range(0, 9)) begin @(negedge clk); #1; end
        end
        wait_done(base + 100, 3000);
        wait_idle(50);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("fifo_drained", 32'(fifo_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
